// File: rtl/ahb_multi_arbiter.sv
// N-master simple-bus arbiter feeding one AHB adapter port; registered one-hot grant.
// Fixed priority by default; define ARB_ROUND_ROBIN_EN for round-robin search.
module ahb_multi_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_dataenable,
   input  logic [NUM_MASTERS-1:0]            m_rd,
   input  logic [NUM_MASTERS-1:0]            m_wr,
   input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
   input  logic [NUM_MASTERS*DATA_W-1:0]     m_wrdata,
   output logic [NUM_MASTERS*DATA_W-1:0]     m_rddata,
   output logic [NUM_MASTERS-1:0]            m_stall,
   output logic [NUM_MASTERS-1:0]            grant,
   output logic [DATA_W/8-1:0]               down_dataenable,
   output logic                              down_rd,
   output logic                              down_wr,
   output logic [ADDR_W-1:0]                 down_address,
   output logic [DATA_W-1:0]                 down_wrdata,
   input  logic [DATA_W-1:0]                 down_rddata,
   input  logic                              down_stall
);

   localparam int BE_W = DATA_W / 8;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] cand;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [NUM_MASTERS-1:0] grant_d;
   logic                   busy;
   logic                   rearb;

   assign req   = m_rd | m_wr;
   assign busy  = |grant_q;
   assign rearb = !busy || !down_stall;
   assign grant = grant_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic [NUM_MASTERS-1:0] last_q;
   logic [NUM_MASTERS-1:0] last_d;

   // Search starts one past the last granted index and wraps.
   function automatic logic [NUM_MASTERS-1:0] pick(
      input logic [NUM_MASTERS-1:0] c,
      input logic [NUM_MASTERS-1:0] last
   );
      logic [NUM_MASTERS-1:0] r;
      logic                   found;
      int                     base;
      r     = '0;
      found = 1'b0;
      base  = 0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (last[i]) base = i;
      for (int off = 1; off <= NUM_MASTERS; off++)
         for (int j = 0; j < NUM_MASTERS; j++)
            if (!found && c[j] && (j == (base + off) % NUM_MASTERS)) begin
               r[j]  = 1'b1;
               found = 1'b1;
            end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
         last_q[NUM_MASTERS-1] <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   function automatic logic [NUM_MASTERS-1:0] pick(
      input logic [NUM_MASTERS-1:0] c
   );
      logic [NUM_MASTERS-1:0] r;
      r = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (c[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      return r;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) grant_q <= '0;
      else        grant_q <= grant_d;
   end

   // The finishing owner's request belongs to the completing transfer.
   always_comb begin
      cand    = '0;
      grant_d = grant_q;
      if (!busy)            cand = req;
      else if (!down_stall) cand = req & ~grant_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d = last_q;
      if (rearb) grant_d = pick(cand, last_q);
      if (rearb && |grant_d) last_d = grant_d;
`else
      if (rearb) grant_d = pick(cand);
`endif
   end

   always_comb begin
      down_dataenable = '0;
      down_address    = '0;
      down_wrdata     = '0;
      down_rd         = |(grant_q & m_rd);
      down_wr         = |(grant_q & m_wr);
      m_rddata        = '0;
      m_stall         = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            down_dataenable |= m_dataenable[i*BE_W +: BE_W];
            down_address    |= m_address[i*ADDR_W +: ADDR_W];
            down_wrdata     |= m_wrdata[i*DATA_W +: DATA_W];
            m_rddata[i*DATA_W +: DATA_W] = down_rddata;
            m_stall[i] = down_stall;
         end else begin
            m_stall[i] = req[i];
         end
      end
   end

endmodule

// File: tb/tb_ahb_multi_arbiter.sv
// Scoreboard bench for ahb_multi_arbiter with four masters.
// Expectations follow ARB_ROUND_ROBIN_EN where behaviour differs.
module tb_ahb_multi_arbiter;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic [NM-1:0] g;
      logic [NM-1:0] st;
      logic          drd;
      logic          dwr;
      logic [AW-1:0] addr;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic [NM*DW/8-1:0] m_dataenable;
   logic [NM-1:0]      m_rd;
   logic [NM-1:0]      m_wr;
   logic [NM*AW-1:0]   m_address;
   logic [NM*DW-1:0]   m_wrdata;
   logic [NM*DW-1:0]   m_rddata;
   logic [NM-1:0]      m_stall;
   logic [NM-1:0]      grant;
   logic [DW/8-1:0]    down_dataenable;
   logic               down_rd;
   logic               down_wr;
   logic [AW-1:0]      down_address;
   logic [DW-1:0]      down_wrdata;
   logic [DW-1:0]      down_rddata;
   logic               down_stall;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   ahb_multi_arbiter #(
      .NUM_MASTERS(NM),
      .ADDR_W(AW),
      .DATA_W(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .m_dataenable(m_dataenable),
      .m_rd(m_rd),
      .m_wr(m_wr),
      .m_address(m_address),
      .m_wrdata(m_wrdata),
      .m_rddata(m_rddata),
      .m_stall(m_stall),
      .grant(grant),
      .down_dataenable(down_dataenable),
      .down_rd(down_rd),
      .down_wr(down_wr),
      .down_address(down_address),
      .down_wrdata(down_wrdata),
      .down_rddata(down_rddata),
      .down_stall(down_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic logic [AW-1:0] addr_of(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h100;
   endfunction

   task automatic do_reset();
      m_rd         = '0;
      m_wr         = '0;
      down_stall   = 1'b0;
      down_rddata  = '0;
      m_dataenable = '1;
      for (int i = 0; i < NM; i++) begin
         m_address[i*AW +: AW] = addr_of(i);
         m_wrdata[i*DW +: DW]  = 32'hA5A5_0000 + 32'(i);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      m_wr  = '0;
      m_rd  = 4'b0101;
      down_stall  = 1'b0;
      down_rddata = 32'h1234_5678;
      #2;
      e = '{g: 4'b0000, st: 4'b0101, drd: 1'b0, dwr: 1'b0, addr: '0};
      total++;
      if (grant !== e.g) begin
         bad++;
         $display("FAIL reset_grant got=%b want=%b", grant, e.g);
      end
      total++;
      if (down_rd !== e.drd) begin
         bad++;
         $display("FAIL reset_down_rd got=%b want=%b", down_rd, e.drd);
      end
      total++;
      if (m_stall !== e.st) begin
         bad++;
         $display("FAIL reset_m_stall got=%b want=%b", m_stall, e.st);
      end
      total++;
      if (m_rddata !== '0) begin
         bad++;
         $display("FAIL reset_m_rddata got=%h want=0", m_rddata);
      end
   endtask

   task automatic test_single_read();
      exp_t e;
      do_reset();
      @(posedge clk);
      #1;
      m_address[2*AW +: AW] = 32'h1FC0_0000;
      down_rddata = 32'hDEAD_BEEF;
      m_rd = 4'b0100;
      sb.push_back('{g: 4'b0000, st: 4'b0100, drd: 1'b0, dwr: 1'b0,
                     addr: '0});
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            @(posedge clk);
            #1;
            sb.push_back('{g: 4'b0100, st: 4'b0000, drd: 1'b1,
                           dwr: 1'b0, addr: 32'h1FC0_0000});
         end
         if (c == 2) begin
            @(posedge clk);
            #1;
            m_rd = '0;
            sb.push_back('{g: 4'b0000, st: 4'b0000, drd: 1'b0,
                           dwr: 1'b0, addr: '0});
         end
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (grant !== e.g) begin
            bad++;
            $display("FAIL rd_grant c%0d got=%b want=%b", c, grant, e.g);
         end
         total++;
         if (m_stall !== e.st) begin
            bad++;
            $display("FAIL rd_stall c%0d got=%b want=%b", c, m_stall, e.st);
         end
         total++;
         if ({down_rd, down_address} !== {e.drd, e.addr}) begin
            bad++;
            $display("FAIL rd_down c%0d got=%b/%h want=%b/%h",
                     c, down_rd, down_address, e.drd, e.addr);
         end
         if (c == 1) begin
            total++;
            if (m_rddata[2*DW +: DW] !== 32'hDEAD_BEEF) begin
               bad++;
               $display("FAIL rd_data got=%h want=deadbeef",
                        m_rddata[2*DW +: DW]);
            end
         end
      end
   endtask

   task automatic test_fixed_priority();
      logic [NM-1:0] wr_t[7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010,
                                 4'b1010, 4'b1000, 4'b0000};
      logic          ds_t[7] = '{1, 1, 1, 1, 0, 0, 0};
      logic [NM-1:0] g_t[7]  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0010, 4'b1000, 4'b0000};
      logic [NM-1:0] st_t[7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010,
                                 4'b1000, 4'b0000, 4'b0000};
      exp_t e;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(posedge clk);
         #1;
         m_wr       = wr_t[c];
         down_stall = ds_t[c];
         e.g   = g_t[c];
         e.st  = st_t[c];
         e.drd = 1'b0;
         e.dwr = |g_t[c];
         e.addr = g_t[c][1] ? addr_of(1) : g_t[c][3] ? addr_of(3) : '0;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (grant !== e.g) begin
            bad++;
            $display("FAIL fp_grant c%0d got=%b want=%b", c, grant, e.g);
         end
         total++;
         if (m_stall !== e.st) begin
            bad++;
            $display("FAIL fp_stall c%0d got=%b want=%b", c, m_stall, e.st);
         end
         total++;
         if ({down_wr, down_address} !== {e.dwr, e.addr}) begin
            bad++;
            $display("FAIL fp_down c%0d got=%b/%h want=%b/%h",
                     c, down_wr, down_address, e.dwr, e.addr);
         end
      end
   endtask

   task automatic test_fairness();
`ifdef ARB_ROUND_ROBIN_EN
      logic [NM-1:0] g_t[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b0001, 4'b0010};
`else
      logic [NM-1:0] g_t[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0001,
                                4'b0010, 4'b0001, 4'b0010};
`endif
      exp_t e;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(posedge clk);
         #1;
         m_rd = 4'b1111;
         down_stall = 1'b0;
         e.g   = g_t[c];
         e.st  = ~g_t[c];
         e.drd = |g_t[c];
         e.dwr = 1'b0;
         e.addr = '0;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (grant !== e.g) begin
            bad++;
            $display("FAIL arb_grant c%0d got=%b want=%b", c, grant, e.g);
         end
         total++;
         if ({m_stall, down_rd} !== {e.st, e.drd}) begin
            bad++;
            $display("FAIL arb_stall c%0d got=%b/%b want=%b/%b",
                     c, m_stall, down_rd, e.st, e.drd);
         end
      end
      m_rd = '0;
   endtask

   task automatic test_dropped_request();
      logic [NM-1:0] wr_t[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic          ds_t[5] = '{1, 1, 1, 0, 0};
      logic [NM-1:0] g_t[5]  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
      logic [NM-1:0] st_t[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic          w_t[5]  = '{0, 1, 0, 0, 0};
      exp_t e;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         m_wr       = wr_t[c];
         down_stall = ds_t[c];
         sb.push_back('{g: g_t[c], st: st_t[c], drd: 1'b0, dwr: w_t[c],
                        addr: '0});
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (grant !== e.g) begin
            bad++;
            $display("FAIL drop_grant c%0d got=%b want=%b", c, grant, e.g);
         end
         total++;
         if ({m_stall, down_wr} !== {e.st, e.dwr}) begin
            bad++;
            $display("FAIL drop_out c%0d got=%b/%b want=%b/%b",
                     c, m_stall, down_wr, e.st, e.dwr);
         end
      end
   endtask

   task automatic test_reset_mid_transfer();
      do_reset();
      @(posedge clk);
      #1;
      m_wr       = 4'b0001;
      down_stall = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({grant, down_wr} !== {4'b0001, 1'b1}) begin
         bad++;
         $display("FAIL mid_pre got=%b/%b want=0001/1", grant, down_wr);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({grant, down_wr} !== {4'b0000, 1'b0}) begin
         bad++;
         $display("FAIL mid_async got=%b/%b want=0000/0", grant, down_wr);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (grant !== 4'b0000) begin
         bad++;
         $display("FAIL mid_idle got=%b want=0000", grant);
      end
      @(negedge clk);
      total++;
      if ({grant, down_wr} !== {4'b0001, 1'b1}) begin
         bad++;
         $display("FAIL mid_regrant got=%b/%b want=0001/1", grant, down_wr);
      end
      m_wr = '0;
   endtask

   initial begin
      m_rd = '0;
      m_wr = '0;
      m_address = '0;
      m_wrdata = '0;
      m_dataenable = '0;
      down_rddata = '0;
      down_stall = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_single_read();
      test_fixed_priority();
      test_fairness();
      test_dropped_request();
      test_reset_mid_transfer();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_multi_arbiter.md
# ahb_multi_arbiter

Parametrised N-master arbiter that multiplexes CPU-side simple memory buses (instruction, data, DMA, debug) onto the single simple-bus port that feeds the AHB master adapter. A registered one-hot grant selects one master at a time, and the grant is held until the downstream port completes the transfer. On completion the grant passes directly to the next pending master, with no idle bubble. Priority is fixed (lowest index wins) by default; round-robin is selectable at compile time.

## Interface
- NUM_MASTERS, 2: number of requesting masters; legal range 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte enables are DATA_W/8 bits wide.

Ports (master i occupies slice i of each packed vector):
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_dataenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables
- m_rd  in  NUM_MASTERS  per-master read request
- m_wr  in  NUM_MASTERS  per-master write request
- m_address  in  NUM_MASTERS*ADDR_W  per-master address
- m_wrdata  in  NUM_MASTERS*DATA_W  per-master write data
- m_rddata  out  NUM_MASTERS*DATA_W  per-master read data
- m_stall  out  NUM_MASTERS  per-master stall
- grant  out  NUM_MASTERS  one-hot registered grant; all zero when idle
- down_dataenable  out  DATA_W/8  byte enables to the adapter
- down_rd  out  1  read strobe to the adapter
- down_wr  out  1  write strobe to the adapter
- down_address  out  ADDR_W  address to the adapter
- down_wrdata  out  DATA_W  write data to the adapter
- down_rddata  in  DATA_W  read data from the adapter
- down_stall  in  1  adapter busy; a transfer completes in any granted cycle with down_stall=0

## Operation
- **Request.** req[i] = m_rd[i] | m_wr[i]. The master must hold its request and payload stable until it sees m_stall[i]=0.
- **States.** IDLE (grant==0) and OWN(k) (grant[k]=1).
- **IDLE.**
  - If any req is set, the next state is OWN(winner).
  - Otherwise the block stays in IDLE.
- **OWN(k), down_stall=1.** Hold OWN(k).
- **OWN(k), down_stall=0 (completion cycle).**
  - Form the candidate set req & ~(1<<k). Master k's request in this cycle belongs to the transfer that is just finishing, so it is excluded.
  - If the candidate set is non-empty, the next state is OWN(winner); otherwise IDLE.
- **Winner selection.** Fixed priority by default: lowest set index wins.
- **Downstream mux.** All down_* payload outputs come from master k while in OWN(k).
  - down_rd = m_rd[k] and down_wr = m_wr[k].
  - In IDLE, every down_* output is 0.
- **Master outputs, per master i.**
  - Granted (grant[i]=1): m_stall[i]=down_stall and m_rddata[i]=down_rddata.
  - Requesting but not granted: m_stall[i]=1 and m_rddata[i]=0.
  - Not requesting: m_stall[i]=0 and m_rddata[i]=0.
- **Dropped request.** If the granted master drops req while in OWN(k) (protocol violation), down_rd and down_wr follow it to 0. The grant is then released on the next down_stall=0 cycle.

## Timing
- **Reset.** While rst_n=0 the block is asynchronously in IDLE.
  - grant=0 and every down_* output=0.
  - m_rddata=0; m_stall[i]=req[i].
  - Round-robin pointer = NUM_MASTERS-1, so master 0 is searched first.
- **Arbitration latency.** One cycle. A request rising in cycle t while IDLE is granted in t+1, and down_rd/down_wr assert in t+1.
- **Best case.** With a zero-wait adapter, a master's stall lasts exactly one cycle.
- **Back-to-back.** Completion in cycle c with another request pending gives the new grant in c+1. There is no IDLE cycle between masters.
- **Same master again.** A master re-requesting right after its own completion re-enters arbitration one cycle later. It is granted in c+2 at the earliest.
- **Output paths.** down_* and m_* are combinational from the grant register and the inputs. grant is the only registered output.
- **Reset mid-transfer.** Asserting rst_n low mid-transfer drops down_rd/down_wr immediately and abandons the in-flight transfer; the adapter must share the reset.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- **Undefined:** fixed priority, lowest index wins.
- **Defined:**
  - A NUM_MASTERS-wide pointer register records the last granted index, updated whenever a new grant is issued.
  - The search starts at pointer+1 and wraps modulo NUM_MASTERS.
  - The completion-cycle exclusion of master k applies unchanged.

## Test plan
- **Reset values.** NUM_MASTERS=4, rst_n=0, m_rd=4'b0101 → grant=0, down_rd=0, m_stall=4'b0101, m_rddata=0.
- **Single read.** Master 2 reads 0x1FC0_0000 with down_stall low and down_rddata=0xDEADBEEF → grant=4'b0100 one cycle later. In that cycle down_address=0x1FC0_0000, m_stall[2]=0 and m_rddata[2]=0xDEADBEEF.
- **Fixed priority.** m_wr=4'b1010 asserted together; down_stall held 1 for 3 cycles, then 0 → master 1 granted first. Master 3 is granted in the cycle after master 1 completes, with no IDLE cycle. m_stall[3]=1 throughout master 1's ownership.
- **Round-robin fairness** (ARB_ROUND_ROBIN_EN defined). All 4 masters request continuously; zero-wait adapter → grant sequence 0,1,2,3,0,1 in consecutive cycles.
- **Starvation under fixed priority** (macro undefined). Same stimulus as round-robin fairness → grant alternates 0,1,0,1: master 0 is excluded only on its completion cycle. Masters 2 and 3 stay stalled.
- **Reset mid-transfer.** Master 0 granted, down_stall=1, rst_n pulsed low → grant and down_wr fall asynchronously within the same cycle. After release with req still high, master 0 is re-granted one cycle later.
